// File: rtl/pc_sequencer.sv
// PC register and next-fetch-address logic with a RUN/HALTED FSM and a taken-branch counter.
// Optional return-address stack enabled by defining PC_SEQUENCER_RAS_EN.
module pc_sequencer #(
  parameter int unsigned         PC_WIDTH    = 64,
  parameter int unsigned         INSTR_SHIFT = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned         CNT_WIDTH   = 16,
  parameter int unsigned         RAS_DEPTH   = 4
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 Stall,
  input  logic                 Halt,
  input  logic [2:0]           BranchMode,
  input  logic                 ALUZero,
  input  logic [PC_WIDTH-1:0]  SignExtImm,
  input  logic [PC_WIDTH-1:0]  RegTarget,
  output logic [PC_WIDTH-1:0]  CurrentPC,
  output logic [PC_WIDTH-1:0]  NextPC,
  output logic [PC_WIDTH-1:0]  LinkAddr,
  output logic                 Taken,
  output logic                 Halted,
  output logic                 MisalignErr,
  output logic [CNT_WIDTH-1:0] BranchCount
);

  typedef enum logic [2:0] {
    MODE_SEQ  = 3'd0,
    MODE_B    = 3'd1,
    MODE_CBZ  = 3'd2,
    MODE_CBNZ = 3'd3,
    MODE_BR   = 3'd4,
    MODE_BL   = 3'd5,
    MODE_RET  = 3'd6,
    MODE_RSVD = 3'd7
  } mode_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(1) << INSTR_SHIFT;
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = STEP - PC_WIDTH'(1);

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  mode_e                 mode;
  logic [PC_WIDTH-1:0]   offset;
  logic [PC_WIDTH-1:0]   seq_pc;
  logic [PC_WIDTH-1:0]   rel_target;
  logic [PC_WIDTH-1:0]   ret_target;
  logic [PC_WIDTH-1:0]   target;
  logic                  taken;
  logic                  misalign;
  logic                  commit;

  assign mode       = mode_e'(BranchMode);
  assign offset     = SignExtImm << INSTR_SHIFT;
  assign seq_pc     = pc_q + STEP;
  assign rel_target = pc_q + offset;

  always_comb begin
    taken  = 1'b0;
    target = seq_pc;
    unique case (mode)
      MODE_B, MODE_BL: begin
        taken  = 1'b1;
        target = rel_target;
      end
      MODE_CBZ: begin
        taken  = ALUZero;
        target = rel_target;
      end
      MODE_CBNZ: begin
        taken  = ~ALUZero;
        target = rel_target;
      end
      MODE_BR: begin
        taken  = 1'b1;
        target = RegTarget;
      end
      MODE_RET: begin
        taken  = 1'b1;
        target = ret_target;
      end
      default: begin
        taken  = 1'b0;
        target = seq_pc;
      end
    endcase
  end

  assign misalign = ((mode == MODE_BR) || (mode == MODE_RET)) &&
                    ((target & ALIGN_MASK) != '0);

  // Only an unstalled, unhalted, aligned cycle in RUN updates architectural state.
  assign commit = (state_q == ST_RUN) && !Halt && !misalign && !Stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (Halt) begin
          state_d = ST_HALTED;
        end else if (misalign) begin
          err_d   = 1'b1;
          state_d = ST_HALTED;
        end else if (!Stall) begin
          pc_d = NextPC;
          if (taken && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_HALTED;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PC_SEQUENCER_RAS_EN
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

  logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]    top_q, top_d;
  logic [PTR_W:0]      level_q, level_d;
  logic                ras_empty;
  logic                ras_push;
  logic                ras_pop;

  assign ras_empty  = (level_q == '0);
  assign ret_target = ras_empty ? RegTarget : ras_mem[top_q];
  assign ras_push   = commit && (mode == MODE_BL);
  assign ras_pop    = commit && (mode == MODE_RET) && !ras_empty;

  // Circular stack: a push when full advances past the oldest slot and overwrites it.
  always_comb begin
    top_d   = top_q;
    level_d = level_q;
    if (ras_push) begin
      top_d = top_q + PTR_W'(1);
      if (level_q != (PTR_W + 1)'(RAS_DEPTH)) begin
        level_d = level_q + (PTR_W + 1)'(1);
      end
    end else if (ras_pop) begin
      top_d   = top_q - PTR_W'(1);
      level_d = level_q - (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      top_q   <= '0;
      level_q <= '0;
    end else begin
      top_q   <= top_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (ras_push) begin
      ras_mem[top_d] <= LinkAddr;
    end
  end
`else
  logic unused_ras_cfg;
  assign ret_target     = RegTarget;
  assign unused_ras_cfg = ^RAS_DEPTH;
`endif

  assign CurrentPC   = pc_q;
  assign NextPC      = taken ? target : seq_pc;
  assign LinkAddr    = seq_pc;
  assign Taken       = taken;
  assign Halted      = (state_q == ST_HALTED);
  assign MisalignErr = err_q;
  assign BranchCount = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a behavioural model checked every cycle on two instances
// (16-bit and 2-bit counters) sharing stimulus, plus directed literal checks.
module tb_pc_sequencer;
  localparam logic [63:0] RST = 64'h100;

  logic        CLK = 1'b0;
  logic        Reset, Stall, Halt, ALUZero;
  logic [2:0]  BranchMode;
  logic [63:0] SignExtImm, RegTarget;

  logic [63:0] a_pc, a_npc, a_link, b_pc, b_npc, b_link;
  logic        a_tk, a_hlt, a_err, b_tk, b_hlt, b_err;
  logic [15:0] a_cnt;
  logic [1:0]  b_cnt;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  pc_sequencer #(.PC_WIDTH(64), .INSTR_SHIFT(2), .RESET_PC(RST), .CNT_WIDTH(16), .RAS_DEPTH(2)) u_dut (
    .CLK(CLK), .Reset(Reset), .Stall(Stall), .Halt(Halt), .BranchMode(BranchMode),
    .ALUZero(ALUZero), .SignExtImm(SignExtImm), .RegTarget(RegTarget),
    .CurrentPC(a_pc), .NextPC(a_npc), .LinkAddr(a_link), .Taken(a_tk),
    .Halted(a_hlt), .MisalignErr(a_err), .BranchCount(a_cnt));

  pc_sequencer #(.PC_WIDTH(64), .INSTR_SHIFT(2), .RESET_PC(RST), .CNT_WIDTH(2), .RAS_DEPTH(2)) u_sat (
    .CLK(CLK), .Reset(Reset), .Stall(Stall), .Halt(Halt), .BranchMode(BranchMode),
    .ALUZero(ALUZero), .SignExtImm(SignExtImm), .RegTarget(RegTarget),
    .CurrentPC(b_pc), .NextPC(b_npc), .LinkAddr(b_link), .Taken(b_tk),
    .Halted(b_hlt), .MisalignErr(b_err), .BranchCount(b_cnt));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural state plus a queue for the return stack.
  logic [63:0] m_pc;
  logic        m_halted, m_err, m_valid = 1'b0;
  int          m_cnt;
  logic [63:0] m_ras [$];

  always @(negedge CLK) begin : model
    logic [63:0] seq, tgt, nxt;
    logic        tk, mis, ras_en;
    ras_en = 1'b0;
`ifdef PC_SEQUENCER_RAS_EN
    ras_en = 1'b1;
`endif
    seq = m_pc + 64'd4;
    tgt = seq;
    tk  = 1'b0;
    case (BranchMode)
      3'd1, 3'd5: begin tk = 1'b1;     tgt = m_pc + SignExtImm * 4; end
      3'd2:       begin tk = ALUZero;  tgt = m_pc + SignExtImm * 4; end
      3'd3:       begin tk = !ALUZero; tgt = m_pc + SignExtImm * 4; end
      3'd4:       begin tk = 1'b1;     tgt = RegTarget; end
      3'd6:       begin tk = 1'b1;     tgt = (ras_en && m_ras.size() > 0) ? m_ras[$] : RegTarget; end
      default:    begin tk = 1'b0; end
    endcase
    nxt = tk ? tgt : seq;
    mis = (BranchMode == 3'd4 || BranchMode == 3'd6) && (tgt % 4 != 0);
    if (m_valid) begin
      check("CurrentPC", a_pc, m_pc);
      check("NextPC", a_npc, nxt);
      check("LinkAddr", a_link, seq);
      check("Taken", a_tk, tk);
      check("Halted", a_hlt, m_halted);
      check("MisalignErr", a_err, m_err);
      check("BranchCount16", a_cnt, (m_cnt > 65535) ? 64'd65535 : 64'(m_cnt));
      check("sat.CurrentPC", b_pc, m_pc);
      check("sat.NextPC", b_npc, nxt);
      check("sat.Halted", b_hlt, m_halted);
      check("sat.MisalignErr", b_err, m_err);
      check("BranchCount2", b_cnt, (m_cnt > 3) ? 64'd3 : 64'(m_cnt));
    end
    if (Reset) begin
      m_pc = RST; m_halted = 1'b0; m_err = 1'b0; m_cnt = 0; m_valid = 1'b1;
      m_ras.delete();
    end else if (m_valid && !m_halted) begin
      if (Halt) m_halted = 1'b1;
      else if (mis) begin m_err = 1'b1; m_halted = 1'b1; end
      else if (!Stall) begin
        if (tk) m_cnt++;
        if (ras_en && BranchMode == 3'd5) begin
          if (m_ras.size() == 2) void'(m_ras.pop_front());
          m_ras.push_back(seq);
        end
        if (ras_en && BranchMode == 3'd6 && m_ras.size() > 0) void'(m_ras.pop_back());
        m_pc = nxt;
      end
    end
  end

  task automatic setin(input logic [2:0] m, input logic z, input logic [63:0] imm,
                       input logic [63:0] rt, input logic st, input logic h);
    BranchMode = m; ALUZero = z; SignExtImm = imm; RegTarget = rt; Stall = st; Halt = h;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_pulse;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  initial begin : stim
    logic [1:0] sat_exp [5];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    Reset = 1'b1;
    setin(3'd0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    tick(); tick();
    Reset = 1'b0;
    check("lit reset pc", a_pc, 64'h100);
    check("lit reset cnt", a_cnt, 0);
    check("lit reset halted", a_hlt, 0);
    check("lit reset err", a_err, 0);

    tick(); check("lit seq1", a_pc, 64'h104);
    tick(); check("lit seq2", a_pc, 64'h108);
    tick(); check("lit seq3", a_pc, 64'h10C);
    check("lit seq cnt", a_cnt, 0);

    setin(3'd7, 1'b0, 64'd5, 64'd0, 1'b0, 1'b0); #1;
    check("lit rsvd taken", a_tk, 0);
    check("lit rsvd npc", a_npc, 64'h110);
    tick();

    setin(3'd1, 1'b0, 64'd60, 64'd0, 1'b0, 1'b0); tick();
    check("lit b to 200", a_pc, 64'h200);

    setin(3'd2, 1'b1, -64'sd2, 64'd0, 1'b0, 1'b0); #1;
    check("lit cbz z1 npc", a_npc, 64'h1F8);
    check("lit cbz z1 taken", a_tk, 1);
    tick();
    check("lit cbz z1 pc", a_pc, 64'h1F8);
    check("lit cbz z1 cnt", a_cnt, 2);

    setin(3'd1, 1'b0, 64'd2, 64'd0, 1'b0, 1'b0); tick();
    setin(3'd2, 1'b0, -64'sd2, 64'd0, 1'b0, 1'b0); #1;
    check("lit cbz z0 npc", a_npc, 64'h204);
    check("lit cbz z0 taken", a_tk, 0);
    tick();
    check("lit cbz z0 cnt", a_cnt, 3);

    setin(3'd3, 1'b0, 64'd63, 64'd0, 1'b0, 1'b0); tick();
    check("lit cbnz pc", a_pc, 64'h300);

    setin(3'd1, 1'b0, 64'd4, 64'd0, 1'b1, 1'b0);
    tick(); check("lit stall1", a_pc, 64'h300);
    tick(); check("lit stall2", a_pc, 64'h300);
    check("lit stall cnt", a_cnt, 4);
    setin(3'd1, 1'b0, 64'd4, 64'd0, 1'b0, 1'b0); tick();
    check("lit unstall pc", a_pc, 64'h310);
    check("lit unstall cnt", a_cnt, 5);
    check("lit link", a_link, 64'h314);

    setin(3'd0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1); tick();
    check("lit halt", a_hlt, 1);
    setin(3'd1, 1'b0, 64'd4, 64'd0, 1'b0, 1'b0); #1;
    check("lit halted npc live", a_npc, 64'h320);
    tick();
    check("lit halted pc frozen", a_pc, 64'h310);
    check("lit halted cnt frozen", a_cnt, 5);

    setin(3'd1, 1'b0, 64'd4, 64'd0, 1'b1, 1'b0);
    reset_pulse();
    check("lit reset mid-halt pc", a_pc, 64'h100);
    check("lit reset mid-halt flag", a_hlt, 0);

    setin(3'd1, 1'b0, 64'd1, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("lit sat cnt2", b_cnt, sat_exp[i]);
      check("lit sat cnt16", a_cnt, 64'(i + 1));
    end

    setin(3'd4, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0); tick();
    setin(3'd0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0); #1;
    check("lit wrap npc", a_npc, 64'h0);
    tick();
    check("lit wrap pc", a_pc, 64'h0);

    setin(3'd4, 1'b0, 64'd0, 64'h402, 1'b0, 1'b1); tick();
    check("lit halt beats misalign", a_err, 0);
    reset_pulse();

    setin(3'd4, 1'b0, 64'd0, 64'h402, 1'b0, 1'b0); tick();
    check("lit misalign err", a_err, 1);
    check("lit misalign halted", a_hlt, 1);
    check("lit misalign pc", a_pc, 64'h100);
    setin(3'd0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0); tick();
    check("lit misalign frozen", a_pc, 64'h100);
    reset_pulse();
    check("lit misalign cleared", a_err, 0);

    setin(3'd4, 1'b0, 64'd0, 64'h406, 1'b1, 1'b0); tick();
    check("lit misalign in stall", a_err, 1);
    reset_pulse();

    setin(3'd6, 1'b0, 64'd0, 64'h10, 1'b0, 1'b0); tick();
    check("lit ret empty", a_pc, 64'h10);
    setin(3'd5, 1'b0, 64'd4, 64'd0, 1'b0, 1'b0); #1;
    check("lit bl link", a_link, 64'h14);
    tick(); tick(); tick();
    check("lit bl chain", a_pc, 64'h40);
    setin(3'd6, 1'b0, 64'd0, 64'h999, 1'b0, 1'b0); #1;
`ifdef PC_SEQUENCER_RAS_EN
    check("lit ras pop1", a_npc, 64'h34);
    tick(); #1;
    check("lit ras pop2", a_npc, 64'h24);
    tick(); #1;
    check("lit ras empty", a_npc, 64'h999);
    tick();
    check("lit ras misalign", a_err, 1);
`else
    check("lit ret as br", a_npc, 64'h999);
    tick();
    check("lit ret misalign", a_err, 1);
    check("lit ret pc frozen", a_pc, 64'h40);
`endif
    reset_pulse();
    tick();
    @(negedge CLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised successor to the combinational next-PC logic: owns the architectural PC register and computes the next fetch address.
- Supports sequential, unconditional, CBZ/CBNZ, register-indirect (BR) and branch-and-link flows, with stall and halt.
- Sits between the control unit/ALU and instruction memory; CurrentPC feeds the I-mem address and LinkAddr feeds the register file write-back mux.

Parameters:
- PC_WIDTH, 64, width of the PC, immediate, register target and link address.
- INSTR_SHIFT, 2, log2 of instruction size in bytes; branch offset = SignExtImm << INSTR_SHIFT; sequential step = 1 << INSTR_SHIFT.
- RESET_PC, 0, PC value loaded on reset.
- CNT_WIDTH, 16, width of the taken-branch counter.
- RAS_DEPTH, 4, return-address-stack entries (used only with the optional feature; power of 2, ≥2).

Ports:
- CLK  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Stall  in  1  hold PC this cycle
- Halt  in  1  request transition to HALTED
- BranchMode  in  3  0=SEQ 1=B 2=CBZ 3=CBNZ 4=BR 5=BL 6=RET 7=reserved(treated as SEQ)
- ALUZero  in  1  zero flag from ALU
- SignExtImm  in  PC_WIDTH  sign-extended word offset
- RegTarget  in  PC_WIDTH  register value for BR/RET
- CurrentPC  out  PC_WIDTH  registered PC
- NextPC  out  PC_WIDTH  combinational next PC
- LinkAddr  out  PC_WIDTH  CurrentPC + step (combinational)
- Taken  out  1  combinational: the current instruction redirects
- Halted  out  1  registered: FSM is in HALTED
- MisalignErr  out  1  registered sticky: a misaligned target was detected
- BranchCount  out  CNT_WIDTH  registered count of committed taken redirects, saturating

Behaviour:
- Reset:
  - CurrentPC=RESET_PC; Halted=0; MisalignErr=0; BranchCount=0; FSM=RUN.
  - Reset wins over every other input, including mid-halt and mid-stall.
- Step = 1 << INSTR_SHIFT. Offset = SignExtImm << INSTR_SHIFT. All sums are modulo 2^PC_WIDTH (wrap silently, no flag).
- Target and Taken per mode:
  - SEQ: no redirect.
  - B, BL: CurrentPC + Offset; always taken.
  - CBZ: CurrentPC + Offset when ALUZero=1.
  - CBNZ: CurrentPC + Offset when ALUZero=0.
  - BR, RET: RegTarget; always taken.
  - NextPC = Taken ? target : CurrentPC + Step.
- Misalignment: a taken BR/RET whose target has any of its low INSTR_SHIFT bits nonzero is misaligned.
- FSM has two states.
  - RUN, in priority order:
    - Halt=1: go to HALTED; PC unchanged.
    - Misaligned: set MisalignErr, go to HALTED; PC unchanged; count unchanged.
    - Stall=1: hold PC and count. Halt and misalignment are still honoured during a stall.
    - Otherwise: CurrentPC<=NextPC; if Taken, BranchCount increments, saturating at all-ones.
  - HALTED: PC, count and MisalignErr are frozen; Halted=1; the only exit is Reset.
- Combinational outputs (NextPC, Taken, LinkAddr) remain live in HALTED, for debug.
- Latency: a redirect is visible on CurrentPC one clock after the decision cycle.

Optional Feature:
- Macro: PC_SEQUENCER_RAS_EN.
- Defined: a RAS_DEPTH-entry return-address stack is instantiated.
  - BL committing in RUN pushes LinkAddr.
  - RET committing in RUN pops, and the target becomes the popped value instead of RegTarget.
  - Push when full overwrites the oldest entry (circular).
  - Pop when empty falls back to RegTarget.
  - Stalled or halted cycles neither push nor pop.
  - Reset empties the stack.
- Undefined: no stack logic; RET behaves exactly like BR.

Test Plan:
- Reset with RESET_PC=0x100, then 3 SEQ cycles -> CurrentPC 0x100, 0x104, 0x108, 0x10C; BranchCount=0.
- PC=0x200, CBZ, SignExtImm=-2: ALUZero=1 -> next PC 0x1F8, Taken=1, count+1. ALUZero=0 -> next PC 0x204, Taken=0.
- PC=0x300, B with Stall=1 for 2 cycles, then Stall=0 -> PC holds 0x300 for 2 cycles, then jumps to the target; count increments once.
- BR with RegTarget=0x402 -> MisalignErr=1, Halted=1, PC frozen; a later Reset pulse -> PC=RESET_PC, both flags clear.
- CNT_WIDTH=2, 5 taken B instructions -> BranchCount = 1, 2, 3, 3, 3.
- With PC_SEQUENCER_RAS_EN, RAS_DEPTH=2: BL at 0x10, BL at 0x20, BL at 0x30, then RET x3 with RegTarget=0x999 -> targets 0x34, 0x24, then 0x999 (oldest entry overwritten, stack empty).
